// File: rtl/ones_run_tx.sv
// rtl/ones_run_tx.sv - serial run generator: LEN ones, GAP zero guard bits, done pulse
module ones_run_tx #(
    parameter int LEN_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONES  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [7:0] GAP_L     = 8'(GAP);
    localparam logic       GAP_IS_1  = (GAP == 1);

    state_t           state_q;
    logic [LEN_W-1:0] ones_q;
    logic [7:0]       gap_q;
    logic             out_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;

    // ones_q is the latched length, counted down so len = 2**LEN_W-1 never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ones_q  <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len != '0) begin
                            state_q <= ONES;
                            ones_q  <= len;
                            out_q   <= 1'b1;
                        end else begin
                            state_q <= GUARD;
                            gap_q   <= GAP_L;
                            done_q  <= GAP_IS_1;
                        end
                    end
                end
                ONES: begin
                    if (ones_q == LEN_W'(1)) begin
                        state_q <= GUARD;
                        ones_q  <= '0;
                        out_q   <= 1'b0;
                        gap_q   <= GAP_L;
                        done_q  <= GAP_IS_1;
                    end else begin
                        ones_q <= ones_q - LEN_W'(1);
                    end
                end
                GUARD: begin
                    if (gap_q == 8'd1) begin
                        state_q <= IDLE;
                        gap_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        gap_q  <= gap_q - 8'd1;
                        done_q <= (gap_q == 8'd2);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
